bcd_addsub_seq: RTL

- Digit-serial sequencer for signed-magnitude multi-digit BCD add/subtract.
- Time-shares one single-digit BCD adder (bcd_add) plus nines_comp across DIGITS digits, least-significant digit first.
- Performs effective subtraction by nine's complement, with an end-around-carry pass or a final recomplement.
- Sits between the operand registers and the result display/register path; uses a start/busy/done handshake.

---
 rtl/bcd_addsub_seq.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/bcd_addsub_seq.sv
// Digit-serial signed-magnitude BCD add/subtract that time-shares one single-digit BCD adder.
// Define BCD_INPUT_CHECK_EN to add the invalid output and reject operands holding non-BCD digits.
module bcd_addsub_seq #(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [4*DIGITS-1:0] a_bcd,
   input  logic                a_sign,
   input  logic [4*DIGITS-1:0] b_bcd,
   input  logic                b_sign,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] result,
   output logic                result_sign,
   output logic                overflow
`ifdef BCD_INPUT_CHECK_EN
   ,
   output logic                invalid
`endif
);

   localparam int W     = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PASS1, S_EAC, S_FIX, S_DONE} state_t;

   function automatic logic [3:0] nines_comp(input logic [3:0] d);
      return 4'd9 - d;
   endfunction

   // Returns {carry_out, sum_digit}.
   function automatic logic [4:0] bcd_add(input logic [3:0] x, input logic [3:0] y, input logic cin);
      logic [4:0] s;
      s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
      if (s > 5'd9) return {1'b1, s[3:0] + 4'd6};
      return {1'b0, s[3:0]};
   endfunction

`ifdef BCD_INPUT_CHECK_EN
   function automatic logic has_bad_digit(input logic [W-1:0] v);
      for (int i = 0; i < DIGITS; i++)
         if (v[i*4 +: 4] > 4'd9) return 1'b1;
      return 1'b0;
   endfunction
`endif

   state_t           state_q, state_d;
   logic [W-1:0]     op_p_q, op_p_d;   // positive operand (or A on effective add)
   logic [W-1:0]     op_n_q, op_n_d;   // negative operand (or B on effective add)
   logic [W-1:0]     work_q, work_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             sub_q, sub_d;
   logic             neg_q, neg_d;
   logic [W-1:0]     result_q, result_d;
   logic             result_sign_q, result_sign_d;
   logic             overflow_q, overflow_d;
`ifdef BCD_INPUT_CHECK_EN
   logic             invalid_q, invalid_d;
`endif

   logic [3:0] add_x, add_y, add_sum;
   logic       add_cout;
   logic       last_digit;

   assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         op_p_q        <= '0;
         op_n_q        <= '0;
         work_q        <= '0;
         idx_q         <= '0;
         carry_q       <= 1'b0;
         sub_q         <= 1'b0;
         neg_q         <= 1'b0;
         result_q      <= '0;
         result_sign_q <= 1'b0;
         overflow_q    <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
         invalid_q     <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         op_p_q        <= op_p_d;
         op_n_q        <= op_n_d;
         work_q        <= work_d;
         idx_q         <= idx_d;
         carry_q       <= carry_d;
         sub_q         <= sub_d;
         neg_q         <= neg_d;
         result_q      <= result_d;
         result_sign_q <= result_sign_d;
         overflow_q    <= overflow_d;
`ifdef BCD_INPUT_CHECK_EN
         invalid_q     <= invalid_d;
`endif
      end
   end

   // The one shared digit adder: operand digits chosen by the current pass.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      add_x = 4'd0;
      add_y = 4'd0;
      case (state_q)
         S_PASS1: begin
            add_x = op_p_q[{idx_q, 2'b00} +: 4];
            add_y = sub_q ? nines_comp(op_n_q[{idx_q, 2'b00} +: 4]) : op_n_q[{idx_q, 2'b00} +: 4];
         end
         S_EAC:   add_x = work_q[{idx_q, 2'b00} +: 4];
         default: ;
      endcase
      {add_cout, add_sum} = bcd_add(add_x, add_y, carry_q);
   end

   logic fin, fin_neg, fin_ovf;

   always_comb begin
      state_d       = state_q;
      op_p_d        = op_p_q;
      op_n_d        = op_n_q;
      work_d        = work_q;
      idx_d         = idx_q;
      carry_d       = carry_q;
      sub_d         = sub_q;
      neg_d         = neg_q;
      result_d      = result_q;
      result_sign_d = result_sign_q;
      overflow_d    = overflow_q;
`ifdef BCD_INPUT_CHECK_EN
      invalid_d     = invalid_q;
`endif
      fin     = 1'b0;
      fin_neg = 1'b0;
      fin_ovf = 1'b0;

      case (state_q)
         S_IDLE: if (start) begin
            sub_d = a_sign ^ b_sign;
            if (a_sign && !b_sign) begin
               op_p_d = b_bcd;
               op_n_d = a_bcd;
            end else begin
               op_p_d = a_bcd;
               op_n_d = b_bcd;
            end
            neg_d   = a_sign;
            idx_d   = '0;
            carry_d = 1'b0;
            work_d  = '0;
            state_d = S_PASS1;
`ifdef BCD_INPUT_CHECK_EN
            if (has_bad_digit(a_bcd) || has_bad_digit(b_bcd)) begin
               state_d       = S_DONE;
               result_d      = '0;
               result_sign_d = 1'b0;
               overflow_d    = 1'b0;
               invalid_d     = 1'b1;
            end
`endif
         end
         S_PASS1: begin
            work_d[{idx_q, 2'b00} +: 4] = add_sum;
            carry_d = add_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (last_digit) begin
               idx_d = '0;
               if (!sub_q) begin
                  fin     = 1'b1;
                  fin_neg = neg_q;
                  fin_ovf = add_cout;
               end else if (add_cout) begin
                  // End-around carry: the final carry becomes the initial carry of the ripple pass.
                  state_d = S_EAC;
               end else begin
                  state_d = S_FIX;
               end
            end
         end
         S_EAC: begin
            work_d[{idx_q, 2'b00} +: 4] = add_sum;
            carry_d = add_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (last_digit) begin
               idx_d = '0;
               fin   = 1'b1;
            end
         end
         S_FIX: begin
            for (int i = 0; i < DIGITS; i++)
               work_d[i*4 +: 4] = nines_comp(work_q[i*4 +: 4]);
            fin     = 1'b1;
            fin_neg = (work_d != '0);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (fin) begin
         state_d       = S_DONE;
         result_d      = work_d;
         result_sign_d = fin_neg;
         overflow_d    = fin_ovf;
`ifdef BCD_INPUT_CHECK_EN
         invalid_d     = 1'b0;
`endif
      end
   end

   always_comb begin
      busy        = (state_q == S_PASS1) || (state_q == S_EAC) || (state_q == S_FIX);
      done        = (state_q == S_DONE);
      result      = result_q;
      result_sign = result_sign_q;
      overflow    = overflow_q;
`ifdef BCD_INPUT_CHECK_EN
      invalid     = invalid_q;
`endif
   end

endmodule
